count_seq_checker: RTL and testbench

- Receive-side checker for the free-running WIDTH-bit up-counter stream.
- Samples count values, acquires lock onto the +1 (mod 2^WIDTH) sequence, then flags and counts sequence violations.
- Sits downstream of the counter, or at the far end of any link carrying its value, as a built-in integrity monitor.

---
 rtl/count_seq_checker.sv | 136 +++++++++++++
 tb/tb_count_seq_checker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module   : count_seq_checker
//  Purpose  : Receive-side integrity checker for a free-running WIDTH-bit
//             up-counter stream. Locks onto the +1 (mod 2^WIDTH) sequence
//             after LOCK_CNT consecutive correct increments, then flags and
//             counts mismatches until LOSS_CNT consecutive mismatches drop
//             lock again.
//  Ports    : clk        - clock, rising-edge
//             rst        - asynchronous active-high reset
//             valid_in   - sample count_in on this edge
//             count_in   - received count value [WIDTH]
//             clear_err  - synchronous clear of err_count
//             locked     - checker is locked to the sequence
//             err_pulse  - one-cycle flag for a mismatch seen while locked
//             err_count  - saturating count of mismatches seen while locked
//             expected   - next value expected (last sample + 1)
//  Revision : 1.0 - initial release
// ============================================================================
module count_seq_checker #(
    parameter int WIDTH     = 4,
    parameter int LOCK_CNT  = 4,
    parameter int LOSS_CNT  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     count_in,
    input  logic                 clear_err,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     expected
);

    // Run counters only ever need to reach their thresholds.
    localparam int c_good_w = $clog2(LOCK_CNT + 1);
    localparam int c_bad_w  = $clog2(LOSS_CNT + 1);
    localparam logic [c_good_w-1:0] c_lock_cnt = c_good_w'(LOCK_CNT);
    localparam logic [c_bad_w-1:0]  c_loss_cnt = c_bad_w'(LOSS_CNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    state_t                r_state;
    logic [WIDTH-1:0]      r_prev;
    logic [c_good_w-1:0]   r_good_run;
    logic [c_bad_w-1:0]    r_bad_run;

    logic [WIDTH-1:0]      w_prev_inc;
    logic [WIDTH-1:0]      w_count_inc;
    logic                  w_match;
    logic [c_good_w-1:0]   w_good_inc;
    logic [c_bad_w-1:0]    w_bad_inc;
    logic                  w_err_sat;

    // Additions are kept at WIDTH bits so 2^WIDTH-1 -> 0 counts as a match.
    assign w_prev_inc  = r_prev + WIDTH'(1);
    assign w_count_inc = count_in + WIDTH'(1);
    assign w_match     = (count_in == w_prev_inc);
    assign w_good_inc  = r_good_run + c_good_w'(1);
    assign w_bad_inc   = r_bad_run + c_bad_w'(1);
    assign w_err_sat   = (err_count == {ERR_CNT_W{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_prev     <= '0;
            r_good_run <= '0;
            r_bad_run  <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_count  <= '0;
            expected   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (valid_in) begin
                // Always resync to whatever was received.
                r_prev   <= count_in;
                expected <= w_count_inc;
                case (r_state)
                    ST_IDLE: begin
                        // First sample only seeds r_prev; nothing to compare.
                        r_state    <= ST_ACQ;
                        r_good_run <= '0;
                    end
                    ST_ACQ: begin
                        if (w_match) begin
                            r_good_run <= w_good_inc;
                            if (w_good_inc == c_lock_cnt) begin
                                r_state   <= ST_LOCK;
                                locked    <= 1'b1;
                                r_bad_run <= '0;
                            end
                        end else begin
                            r_good_run <= '0;
                        end
                    end
                    ST_LOCK: begin
                        if (w_match) begin
                            r_bad_run <= '0;
                        end else begin
                            // The mismatch that drops lock is still reported.
                            err_pulse <= 1'b1;
                            if (!w_err_sat) begin
                                err_count <= err_count + ERR_CNT_W'(1);
                            end
                            if (w_bad_inc == c_loss_cnt) begin
                                r_state    <= ST_ACQ;
                                locked     <= 1'b0;
                                r_good_run <= '0;
                                r_bad_run  <= '0;
                            end else begin
                                r_bad_run <= w_bad_inc;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        locked  <= 1'b0;
                    end
                endcase
            end
            // Clear overrides any increment made on the same edge.
            if (clear_err) begin
                err_count <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_count_seq_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_count_seq_checker
//  Purpose  : Self-checking bench for count_seq_checker. A behavioural model
//             tracks lock status, run lengths and error count from the
//             sequence rules; a compare process checks all outputs on every
//             falling edge, and directed steps pin key values as literals.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_count_seq_checker;

    localparam int WIDTH     = 4;
    localparam int LOCK_CNT  = 4;
    localparam int LOSS_CNT  = 2;
    localparam int ERR_CNT_W = 8;
    localparam int MODV      = 1 << WIDTH;
    localparam int ERR_MAX   = (1 << ERR_CNT_W) - 1;

    logic                 clk;
    logic                 rst;
    logic                 valid_in;
    logic [WIDTH-1:0]     count_in;
    logic                 clear_err;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_CNT_W-1:0] err_count;
    logic [WIDTH-1:0]     expected;

    count_seq_checker #(
        .WIDTH     (WIDTH),
        .LOCK_CNT  (LOCK_CNT),
        .LOSS_CNT  (LOSS_CNT),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .count_in  (count_in),
        .clear_err (clear_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .expected  (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Behavioural model state
    bit m_seen;
    bit m_locked;
    bit m_pulse;
    int m_prev;
    int m_exp;
    int m_errs;
    int m_good;
    int m_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_seen   = 1'b0;
        m_locked = 1'b0;
        m_pulse  = 1'b0;
        m_prev   = 0;
        m_exp    = 0;
        m_errs   = 0;
        m_good   = 0;
        m_bad    = 0;
    endtask

    task automatic model_step(input bit v, input int c, input bit clr);
        bit hit;
        m_pulse = 1'b0;
        if (v) begin
            hit = (c == (m_prev + 1) % MODV);
            if (!m_seen) begin
                m_seen = 1'b1;
                m_good = 0;
            end else if (!m_locked) begin
                if (hit) begin
                    m_good++;
                    if (m_good >= LOCK_CNT) begin
                        m_locked = 1'b1;
                        m_bad    = 0;
                    end
                end else begin
                    m_good = 0;
                end
            end else begin
                if (hit) begin
                    m_bad = 0;
                end else begin
                    m_pulse = 1'b1;
                    if (m_errs < ERR_MAX) m_errs++;
                    m_bad++;
                    if (m_bad >= LOSS_CNT) begin
                        m_locked = 1'b0;
                        m_good   = 0;
                    end
                end
            end
            m_prev = c;
            m_exp  = (c + 1) % MODV;
        end
        if (clr) m_errs = 0;
    endtask

    // Drive one cycle, advance the model at the edge, return at the falling edge.
    task automatic tick(input bit v, input int c, input bit clr);
        valid_in  = v;
        count_in  = WIDTH'(c);
        clear_err = clr;
        @(posedge clk);
        model_step(v, c, clr);
        @(negedge clk);
    endtask

    // Single compare process: every falling edge, outputs vs. model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("locked",    32'(locked),    32'(m_locked));
            check("err_pulse", 32'(err_pulse), 32'(m_pulse));
            check("err_count", 32'(err_count), 32'(m_errs));
            check("expected",  32'(expected),  32'(m_exp));
        end
    end

    initial begin
        rst       = 1'b1;
        valid_in  = 1'b0;
        count_in  = '0;
        clear_err = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Reset state
        check("rst_locked",    32'(locked),    0);
        check("rst_err_pulse", 32'(err_pulse), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_expected",  32'(expected),  0);

        // Acquisition: 0..4 locks after the fifth sample
        for (int i = 0; i < 4; i++) tick(1'b1, i, 1'b0);
        check("acq_not_yet_locked", 32'(locked), 0);
        tick(1'b1, 4, 1'b0);
        check("acq_locked",   32'(locked),    1);
        check("acq_expected", 32'(expected),  5);
        check("acq_errcnt",   32'(err_count), 0);

        // Wrap-around is a match
        for (int i = 5; i <= 15; i++) tick(1'b1, i, 1'b0);
        tick(1'b1, 0, 1'b0);
        tick(1'b1, 1, 1'b0);
        check("wrap_locked",   32'(locked),    1);
        check("wrap_errcnt",   32'(err_count), 0);
        check("wrap_expected", 32'(expected),  2);

        // Single injected error while locked
        for (int i = 2; i <= 6; i++) tick(1'b1, i, 1'b0);
        tick(1'b1, 9, 1'b0);
        check("inj_pulse",  32'(err_pulse), 1);
        check("inj_errcnt", 32'(err_count), 1);
        check("inj_locked", 32'(locked),    1);
        tick(1'b1, 10, 1'b0);
        check("inj_pulse_drop", 32'(err_pulse), 0);
        tick(1'b1, 11, 1'b0);
        check("inj_locked2",  32'(locked),    1);
        check("inj_expected", 32'(expected),  12);
        check("inj_errcnt2",  32'(err_count), 1);

        // Clear on a matching sample, then two consecutive mismatches drop lock
        tick(1'b1, 12, 1'b1);
        check("clr_errcnt", 32'(err_count), 0);
        tick(1'b1, 3, 1'b0);
        check("loss_first_locked", 32'(locked), 1);
        tick(1'b1, 9, 1'b0);
        check("loss_errcnt", 32'(err_count), 2);
        check("loss_locked", 32'(locked),    0);
        check("loss_pulse",  32'(err_pulse), 1);
        tick(1'b1, 10, 1'b0);
        check("reacq_pulse", 32'(err_pulse), 0);
        tick(1'b1, 11, 1'b0);
        tick(1'b1, 12, 1'b0);
        check("reacq_not_yet", 32'(locked), 0);
        tick(1'b1, 13, 1'b0);
        check("relock",        32'(locked),    1);
        check("relock_errcnt", 32'(err_count), 2);

        // Saturation: alternate mismatch/match so lock is never lost
        for (int i = 0; i < 260; i++) begin
            tick(1'b1, (m_prev + 5) % MODV, 1'b0);
            tick(1'b1, (m_prev + 1) % MODV, 1'b0);
        end
        check("sat_errcnt", 32'(err_count), 255);
        check("sat_locked", 32'(locked),    1);
        tick(1'b1, (m_prev + 5) % MODV, 1'b0);
        check("sat_hold",  32'(err_count), 255);
        check("sat_pulse", 32'(err_pulse), 1);
        tick(1'b1, (m_prev + 1) % MODV, 1'b0);
        tick(1'b1, (m_prev + 5) % MODV, 1'b1);
        check("clr_vs_err_count", 32'(err_count), 0);
        check("clr_vs_err_pulse", 32'(err_pulse), 1);
        check("clr_vs_err_lock",  32'(locked),    1);
        tick(1'b1, (m_prev + 1) % MODV, 1'b0);

        // Hold with valid_in low after a mismatch
        begin
            int v;
            v = (m_prev + 5) % MODV;
            tick(1'b1, v, 1'b0);
            for (int i = 0; i < 5; i++) begin
                tick(1'b0, int'($urandom_range(0, MODV - 1)), 1'b0);
                check("hold_pulse",  32'(err_pulse), 0);
                check("hold_locked", 32'(locked),    1);
            end
            check("hold_errcnt",   32'(err_count), 1);
            check("hold_expected", 32'(expected),  32'((v + 1) % MODV));
        end

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("arst_locked",   32'(locked),    0);
        check("arst_errcnt",   32'(err_count), 0);
        check("arst_expected", 32'(expected),  0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 7, 1'b0);
        check("post_rst_pulse",    32'(err_pulse), 0);
        check("post_rst_locked",   32'(locked),    0);
        check("post_rst_expected", 32'(expected),  8);
        for (int i = 8; i <= 10; i++) tick(1'b1, i, 1'b0);
        check("post_rst_not_yet", 32'(locked), 0);
        tick(1'b1, 11, 1'b0);
        check("post_rst_lock", 32'(locked), 1);

        // Randomised traffic against the model
        for (int i = 0; i < 2000; i++) begin
            bit v;
            bit clr;
            int c;
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 9) < 8) c = (m_prev + 1) % MODV;
            else c = int'($urandom_range(0, MODV - 1));
            tick(v, c, clr);
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
